// File: rtl/ysyx_22050612_mdu_pkg.sv
// Shared types and helpers for the RV64M multiply/divide unit.
package ysyx_22050612_mdu_pkg;

    localparam int unsigned MDU_XLEN = 64;
    localparam int unsigned ITER_W   = $clog2(MDU_XLEN + 1);

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic op_is_w(input mdu_op_e op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic op_is_mulh(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/ysyx_22050612_muldiv_unit_div_iter.sv
// One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
module ysyx_22050612_div_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          ge;

    always_comb begin
        rem_sh = {rem_i, quot_i[XLEN-1]};
        ge     = (rem_sh >= {1'b0, divisor_i});
        diff   = rem_sh - {1'b0, divisor_i};
        rem_o  = ge ? XLEN'(diff) : XLEN'(rem_sh);
        quot_o = {quot_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/ysyx_22050612_muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to compute MUL* ops in a single cycle with a native multiplier.
module ysyx_22050612_muldiv_unit
    import ysyx_22050612_mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d, op_eff;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               neg_q, neg_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d, opa_q, opa_d;
    logic [XLEN-1:0]    opb_q, opb_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;

    logic               accept, go_done;
    logic               sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]    src_a, src_b, mag_a, mag_b, min_val;
    logic [XLEN-1:0]    div_rem, div_quot, div_sel, div_fix, res_raw, fix_res;
    logic [2*XLEN-1:0]  mul_fix;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign accept     = in_valid && in_ready_q && !flush;

    // Operand preparation at accept: W extension, magnitudes and result sign.
    always_comb begin
        op_eff  = (in_op > 4'd12) ? OP_MUL : mdu_op_e'(in_op);
        sgn_a   = op_eff inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        sgn_b   = op_eff inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        src_a   = in_src1;
        src_b   = in_src2;
        if (op_is_w(op_eff)) begin
            src_a = sgn_a ? XLEN'(sext32(in_src1[31:0])) : XLEN'(in_src1[31:0]);
            src_b = sgn_b ? XLEN'(sext32(in_src2[31:0])) : XLEN'(in_src2[31:0]);
        end
        neg_a    = sgn_a && src_a[XLEN-1];
        neg_b    = sgn_b && src_b[XLEN-1];
        mag_a    = neg_a ? -src_a : src_a;
        mag_b    = neg_b ? -src_b : src_b;
        min_val  = op_is_w(op_eff) ? XLEN'(sext32(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (src_b == '0);
        div_ovf  = sgn_b && (src_a == min_val) && (src_b == '1);
    end

`ifdef MDU_FAST_MUL_EN
    assign go_done = !op_is_div(op_eff);
`else
    assign go_done = 1'b0;
`endif

    ysyx_22050612_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quot_i    (acc_q[XLEN-1:0]),
        .divisor_i (opa_q[XLEN-1:0]),
        .rem_o     (div_rem),
        .quot_o    (div_quot)
    );

    // Sign fix-up and half/word selection of the finished result.
    always_comb begin
        mul_fix = neg_q ? -acc_q : acc_q;
        div_sel = op_is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_fix = neg_q ? -div_sel : div_sel;
        if (op_is_div(op_q)) begin
            res_raw = div_fix;
        end else if (op_is_mulh(op_q)) begin
            res_raw = mul_fix[2*XLEN-1:XLEN];
        end else begin
            res_raw = mul_fix[XLEN-1:0];
        end
        fix_res = op_is_w(op_q) ? XLEN'(sext32(res_raw[31:0])) : res_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = go_done ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q <= ITER_W'(1)) state_d = ST_DONE;
            ST_DONE: if (out_valid_q && out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Datapath and output next-values; a zero count means the result is already final.
    always_comb begin
        op_d         = op_q;
        tag_d        = tag_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op_eff;
                    tag_d = in_tag;
                    opb_d = '0;
                    cnt_d = op_is_w(op_eff) ? ITER_W'(32) : ITER_W'(XLEN);
                    if (op_is_div(op_eff)) begin
                        neg_d = op_is_rem(op_eff) ? neg_a : (neg_a ^ neg_b);
                        opa_d = (2*XLEN)'(mag_b);
                        if (div_zero) begin
                            cnt_d = '0;
                            neg_d = 1'b0;
                            acc_d = {src_a, {XLEN{1'b1}}};
                        end else if (div_ovf) begin
                            cnt_d = '0;
                            neg_d = 1'b0;
                            acc_d = {{XLEN{1'b0}}, src_a};
                        end else begin
                            acc_d = {{XLEN{1'b0}}, op_is_w(op_eff) ? (mag_a << 32) : mag_a};
                        end
                    end else begin
                        neg_d = neg_a ^ neg_b;
`ifdef MDU_FAST_MUL_EN
                        acc_d = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
                        opa_d = '0;
`else
                        acc_d = '0;
                        opa_d = (2*XLEN)'(mag_a);
                        opb_d = mag_b;
`endif
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ITER_W'(1);
                    if (op_is_div(op_q)) begin
                        acc_d = {div_rem, div_quot};
                    end else begin
                        acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_result_d = fix_res;
                    out_tag_d    = tag_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (flush) out_valid_d = 1'b0;
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OP_MUL;
            tag_q        <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            op_q         <= op_d;
            tag_q        <= tag_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_muldiv_unit.sv
// Directed bench for the multiply/divide unit; mul latencies follow MDU_FAST_MUL_EN.
module tb_ysyx_22050612_muldiv_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int ML64 = 1;
    localparam int ML32 = 1;
`else
    localparam int ML64 = 65;
    localparam int ML32 = 33;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    ysyx_22050612_muldiv_unit #(.XLEN(64), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        send(op, a, b, tag);
        wait_valid(lat);
        check(name, out_result, exp);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        step();
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 4'd0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        step();

        run_op("divu",      4'd5,  64'd100, 64'd7, 5'd11, 64'd14, 65);
        run_op("remu",      4'd7,  64'd100, 64'd7, 5'd12, 64'd2, 65);
        run_op("div_neg",   4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_neg",   4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, ONES, 65);
        run_op("div_ovf",   4'd4,  64'h8000_0000_0000_0000, ONES, 5'd3, 64'h8000_0000_0000_0000, 2);
        run_op("divu_zero", 4'd5,  64'd123, 64'd0, 5'd4, ONES, 2);
        run_op("remu_zero", 4'd7,  64'd42, 64'd0, 5'd5, 64'd42, 2);
        run_op("divw_zero", 4'd9,  64'd5, 64'd0, 5'd6, ONES, 2);
        run_op("divuw",     4'd10, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd7, ONES, 33);
        run_op("remw_neg",  4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, ONES, 33);
        run_op("divw_neg",  4'd9,  64'd100, 64'h0000_0000_FFFF_FFF9, 5'd9, 64'hFFFF_FFFF_FFFF_FFF2, 33);
        run_op("divw_ovf",  4'd9,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10,
               64'hFFFF_FFFF_8000_0000, 2);
        run_op("mulh",      4'd1,  ONES, ONES, 5'd13, 64'd0, ML64);
        run_op("mulhu",     4'd3,  ONES, 64'd2, 5'd14, 64'd1, ML64);
        run_op("mulw",      4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFE, ML32);
        run_op("mulhsu",    4'd2,  ONES, 64'd2, 5'd16, ONES, ML64);
        run_op("mul",       4'd0,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd17, 64'hFFFF_FFFF_FFFF_FFF1, ML64);
        run_op("illegal",   4'd15, 64'd3, 64'd5, 5'd18, 64'd15, ML64);

        // Back-pressure: result and tag hold while the consumer stalls.
        out_ready = 1'b0;
        send(4'd5, 64'd50, 64'd5, 5'd7);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", out_result, 64'd10);
            check("bp_tag", 64'(out_tag), 64'd7);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);

        // Flush in the middle of a divide.
        send(4'd5, 64'd1000, 64'd3, 5'd9);
        repeat (19) step();
        check("flush_busy", 64'(in_ready), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", 64'(in_ready), 64'd1);
        check("flush_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (80) begin
            step();
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush beats a simultaneous request.
        in_op = 4'd5; in_src1 = 64'd4; in_src2 = 64'd0; in_tag = 5'd20;
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_no_accept", 64'(in_ready), 64'd1);
        repeat (3) step();
        check("flush_no_accept_valid", 64'(out_valid), 64'd0);

        run_op("post_flush", 4'd5, 64'd1000, 64'd3, 5'd21, 64'd333, 65);

        // Reset during CALC clears everything, including the last result.
        send(4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd13);
        repeat (10) step();
        rst = 1'b1;
        step();
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_result", out_result, 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        step();

        run_op("post_rst", 4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd22, 64'hFFFF_FFFF_FFFF_FFFE, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
